// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RV32/RV64 immediate-generation stage.
// Decodes format and sign-extended immediate from the incoming instruction,
// holds up to two decoded entries (main + skid) so that in_ready is a pure
// register, and supports a synchronous flush for branch redirect.
// Optional feature: define IMM_ILLEGAL_CNT_EN to add a saturating 16-bit
// count of accepted illegal instructions on port illegal_count.
module imm_decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMM_ILLEGAL_CNT_EN
  ,
  output logic [15:0]     illegal_count
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  logic   accept;
  logic   drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = (state_q != EMPTY) & out_ready;

  // Combinational decode of the incoming instruction into a full entry.
  always_comb begin
    dec         = '0;
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b0;
    unique case (in_inst[6:0])
      OP_ARITH: begin
        dec.fmt = FMT_R;
        dec.imm = '0;
      end
      OP_IMM: begin
        dec.fmt = FMT_I;
        // Shifts carry a bare shamt; funct7 (e.g. SRAI) is intentionally dropped.
        if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101)
          dec.imm = XLEN'(in_inst[20 +: SHAMT_W]);
        else
          dec.imm = XLEN'($signed(in_inst[31:20]));
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_inst[31:20]));
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
      end
      default: begin
        dec.fmt     = FMT_ILL;
        dec.imm     = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Next-state and entry routing for the main/skid pair; flush wins last.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = dec;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = dec;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = dec;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d = (state_d != FULL);
  end

  // State, ready and entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      main_q.fmt  <= FMT_ILL;
      skid_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

`ifdef IMM_ILLEGAL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of accepted illegal instructions; counts the handshake
  // even when a same-cycle flush drops the entry, and flush never clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign illegal_count = cnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed and randomized checks of imm_decode_stage
// against a queue-based reference model with arithmetic immediate decode.
module tb_imm_decode_stage;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
`ifdef IMM_ILLEGAL_CNT_EN
  logic [15:0]     illegal_count;
  int unsigned     ref_cnt = 0;
`endif

  imm_decode_stage #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal)
`ifdef IMM_ILLEGAL_CNT_EN
    ,
    .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    int              fmt;
    bit              ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Immediate computed as a signed integer from bit fields, then truncated.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    exp_t        r;
    longint      w;
    longint      v;
    logic [63:0] vv;
    int          op;
    int          f3;
    w = longint'(inst);
    op = int'(w & 'h7F);
    f3 = int'((w >> 12) & 7);
    r.inst = inst;
    r.pc   = pc;
    r.ill  = 1'b0;
    r.fmt  = 7;
    v = 0;
    case (op)
      'h33: r.fmt = 0;
      'h13, 'h03, 'h67, 'h73: begin
        r.fmt = 1;
        if (op == 'h13 && (f3 == 1 || f3 == 5)) v = (w >> 20) % (64'sd1 << SHAMT_W);
        else begin
          v = w >> 20;
          if (v >= 2048) v = v - 4096;
        end
      end
      'h23: begin
        r.fmt = 2;
        v = ((w >> 25) << 5) | ((w >> 7) & 'h1F);
        if (v >= 2048) v = v - 4096;
      end
      'h63: begin
        r.fmt = 3;
        v = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
            (((w >> 25) & 'h3F) << 5) | (((w >> 8) & 'hF) << 1);
        if (v >= 4096) v = v - 8192;
      end
      'h37, 'h17: begin
        r.fmt = 4;
        v = w & 'hFFFFF000;
        if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
      end
      'h6F: begin
        r.fmt = 5;
        v = (((w >> 31) & 1) << 20) | (((w >> 12) & 'hFF) << 12) |
            (((w >> 20) & 1) << 11) | (((w >> 21) & 'h3FF) << 1);
        if (v >= (64'sd1 << 20)) v = v - (64'sd1 << 21);
      end
      default: begin
        r.fmt = 7;
        r.ill = 1'b1;
      end
    endcase
    vv = v;
    r.imm = vv[XLEN-1:0];
    return r;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check_eq("out_inst", 64'(out_inst), 64'(q[0].inst));
      check_eq("out_pc", 64'(out_pc), 64'(q[0].pc));
      check_eq("out_imm", 64'(out_imm), 64'(q[0].imm));
      check_eq("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
      check_eq("out_illegal", 64'(out_illegal), 64'(q[0].ill));
    end
`ifdef IMM_ILLEGAL_CNT_EN
    check_eq("illegal_count", 64'(illegal_count), 64'(ref_cnt));
`endif
  endtask

  // Drive one cycle, advance the model, then sample after the edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] pc,
                      input logic ordy, input logic fl);
    exp_t e;
    bit   acc;
    bit   drn;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    e   = ref_decode(inst, pc);
    acc = v && (q.size() < 2);
    drn = (q.size() != 0) && ordy;
`ifdef IMM_ILLEGAL_CNT_EN
    if (acc && e.ill && ref_cnt < 65535) ref_cnt++;
`endif
    if (drn) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  localparam logic [XLEN-1:0] ALL1  = '1;
  localparam logic [XLEN-1:0] NEG4  = ~XLEN'(3);
  localparam logic [31:0]     INS_A = 32'h00A00513;
  localparam logic [31:0]     INS_B = 32'h00B12023;
  localparam logic [31:0]     INS_C = 32'h008000EF;

  initial begin
    logic [6:0]  ops[11];
    logic [31:0] r;
    logic [31:0] ins;
    logic [63:0] p;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_inst = 32'h7F; in_pc = '0; out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_inst", 64'(out_inst), 64'd0);
    check_eq("rst_out_pc", 64'(out_pc), 64'd0);
    check_eq("rst_out_imm", 64'(out_imm), 64'd0);
    check_eq("rst_out_fmt", 64'(out_fmt), 64'd7);
    check_eq("rst_out_illegal", 64'(out_illegal), 64'd0);
`ifdef IMM_ILLEGAL_CNT_EN
    check_eq("rst_count", 64'(illegal_count), 64'd0);
`endif
    in_valid = 1'b0; flush = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    step(1'b1, 32'hFFF00093, XLEN'(32'h100), 1'b1, 1'b0);
    check_eq("addi_valid", 64'(out_valid), 64'd1);
    check_eq("addi_imm", 64'(out_imm), 64'(ALL1));
    check_eq("addi_fmt", 64'(out_fmt), 64'd1);
    step(1'b1, 32'hFE000EE3, XLEN'(32'h104), 1'b1, 1'b0);
    check_eq("beq_imm", 64'(out_imm), 64'(NEG4));
    check_eq("beq_fmt", 64'(out_fmt), 64'd3);
    step(1'b1, 32'h123450B7, XLEN'(32'h108), 1'b1, 1'b0);
    check_eq("lui_imm", 64'(out_imm), 64'h12345000);
    check_eq("lui_fmt", 64'(out_fmt), 64'd4);
    step(1'b1, 32'h4030D093, XLEN'(32'h10C), 1'b1, 1'b0);
    check_eq("srai_imm", 64'(out_imm), 64'd3);
    check_eq("srai_fmt", 64'(out_fmt), 64'd1);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);

    // Back-pressure: three offered, two taken, ready drops after the second.
    step(1'b1, INS_A, XLEN'(32'h200), 1'b0, 1'b0);
    check_eq("bp_ready1", 64'(in_ready), 64'd1);
    step(1'b1, INS_B, XLEN'(32'h204), 1'b0, 1'b0);
    check_eq("bp_ready2", 64'(in_ready), 64'd0);
    step(1'b1, INS_C, XLEN'(32'h208), 1'b0, 1'b0);
    check_eq("bp_hold_inst", 64'(out_inst), 64'(INS_A));
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    check_eq("bp_second", 64'(out_inst), 64'(INS_B));
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    check_eq("bp_empty", 64'(out_valid), 64'd0);

    // Flush while full with a same-cycle input.
    step(1'b1, INS_A, XLEN'(32'h300), 1'b0, 1'b0);
    step(1'b1, INS_B, XLEN'(32'h304), 1'b0, 1'b0);
    step(1'b1, INS_C, XLEN'(32'h308), 1'b0, 1'b1);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_ready", 64'(in_ready), 64'd1);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    check_eq("flush_dropped", 64'(out_valid), 64'd0);

    // Illegal opcode.
    step(1'b1, 32'h0000007F, XLEN'(32'h400), 1'b1, 1'b0);
    step(1'b1, 32'h0000007F, XLEN'(32'h404), 1'b1, 1'b0);
    check_eq("ill_flag", 64'(out_illegal), 64'd1);
    check_eq("ill_fmt", 64'(out_fmt), 64'd7);
    check_eq("ill_imm", 64'(out_imm), 64'd0);
`ifdef IMM_ILLEGAL_CNT_EN
    check_eq("ill_count2", 64'(illegal_count), 64'd2);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r   = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 10)]};
      if (ins[6:0] == 7'h13 && r[0]) ins[14:12] = r[1] ? 3'b001 : 3'b101;
      p = {$urandom(), $urandom()};
      step(($urandom_range(0, 9) < 7), ins, p[XLEN-1:0],
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-operation.
    step(1'b1, INS_A, XLEN'(32'h500), 1'b0, 1'b0);
    step(1'b1, INS_B, XLEN'(32'h504), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_ready", 64'(in_ready), 64'd1);
    check_eq("arst_fmt", 64'(out_fmt), 64'd7);
    q.delete();
`ifdef IMM_ILLEGAL_CNT_EN
    ref_cnt = 0;
`endif
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, INS_C, XLEN'(32'h600), 1'b1, 1'b0);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered immediate-generation stage for the pipelined RV32/RV64 core; sits between the IF/ID boundary and the register-read logic.
- Accepts one instruction and PC per cycle over a valid/ready handshake.
- Classifies the instruction format, produces the sign-extended immediate at XLEN width, and flags unknown opcodes.
- Includes a 2-entry skid buffer so back-pressure never creates a combinational ready path, plus a synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width of out_imm, in_pc and out_pc; legal values are 32 or 64.
- SHAMT_W, 5, shift-amount width for immediate shifts; use 6 when XLEN=64.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  in_inst and in_pc are valid.
- in_ready  output  1  stage can accept; registered.
- in_inst  input  32  raw instruction.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  outputs hold a decoded instruction.
- out_ready  input  1  consumer accepts this cycle.
- out_inst  output  32  instruction passed through.
- out_pc  output  XLEN  PC passed through.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  output  1  opcode not in the opcodes.v set.

Behaviour:
- Reset: state EMPTY. out_valid=0, in_ready=1. out_inst, out_pc, out_imm=0. out_fmt=7, out_illegal=0.
- Decode is combinational on in_inst and is captured on acceptance. Latency from accept to out_valid is 1 cycle.
- Opcode to format:
  - ARITHMETIC: R, imm=0.
  - ARITHMETIC_IMM, LOAD, JALR, ECALL: I, imm=sext(inst[31:20]).
  - STORE: S, imm=sext({inst[31:25],inst[11:7]}).
  - BRANCH: B, imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - LUI, AUIPC: U, imm=sext({inst[31:12],12'b0}).
  - JAL: J, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Any other opcode: fmt=7, imm=0, out_illegal=1.
- Shift exception: ARITHMETIC_IMM with funct3 001 or 101 gives imm = zero-extended inst[20+SHAMT_W-1:20]. This ignores funct7, so SRAI yields the bare shamt.
- Sign extension always uses inst[31] and fills up to XLEN.
- Handshake: transfer on in_valid&in_ready and on out_valid&out_ready. Data is held stable while out_valid&!out_ready.
- States:
  - EMPTY (no entry): accept → ONE.
  - ONE (main entry valid):
    - accept & !drain → FULL, new entry goes to skid.
    - accept & drain → ONE, main replaced.
    - drain & !accept → EMPTY.
  - FULL (main + skid):
    - drain moves skid to main → ONE.
    - in_ready=0; no accept possible.
- in_ready = (next state != FULL), registered.
- Flush: synchronous, highest priority. Next state EMPTY and out_valid=0 next cycle. A same-cycle input is dropped and a same-cycle drain still completes. Flush during reset has no effect.
- Asynchronous reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: IMM_ILLEGAL_CNT_EN.
- Defined: adds output illegal_count [15:0], reset 0.
  - Increments by 1 on each accepted instruction whose decode is illegal.
  - Saturates at 0xFFFF.
  - Not cleared by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then in_inst=0xFFF00093 (addi -1), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1.
- in_inst=0xFE000EE3 (beq -4) → out_imm=0xFFFFFFFC, fmt=3; with XLEN=64 → 0xFFFFFFFFFFFFFFFC.
- in_inst=0x123450B7 (lui) → out_imm=0x12345000, fmt=4.
- in_inst=0x4030D093 (srai 3) → out_imm=0x00000003 (not 0x403), fmt=1.
- Back-pressure:
  - Hold out_ready=0 and stream 3 valid instructions → 2 accepted, in_ready=0 from the cycle after the 2nd accept.
  - Release out_ready → outputs appear in order with no loss or duplication.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, input dropped.
- With IMM_ILLEGAL_CNT_EN defined, in_inst=0x0000007F ×2 → out_illegal=1 and illegal_count=2.
